// File: rtl/button_conditioner_if.sv
// Push-button conditioner signal bundle.
// master: the side driving the raw button (board pin or bench).
// slave:  the conditioner itself.
interface button_conditioner_if;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic en_level;

  modport master (
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  en_level
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output en_level
  );
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, tick-sampled debouncer and a
// press/long-press FSM emitting one-cycle pulses plus a toggling enable level.
// Optional feature macro: AUTO_REPEAT_EN (auto-repeat press pulses while in LONG).
module button_conditioner #(
  parameter int SAMPLE_DIV   = 8,
  parameter int DEB_CYCLES   = 4,
  parameter int HOLD_TICKS   = 64,
  parameter int REPEAT_TICKS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  button_conditioner_if.slave   bus
);

  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  // Elaboration-time parameter range checks.
  if (SAMPLE_DIV < 1) begin : g_chk_div
    $error("SAMPLE_DIV must be >= 1");
  end
  if (DEB_CYCLES < 2 || DEB_CYCLES > 16) begin : g_chk_deb
    $error("DEB_CYCLES must be in 2..16");
  end
  if (HOLD_TICKS < 1) begin : g_chk_hold
    $error("HOLD_TICKS must be >= 1");
  end
  if (REPEAT_TICKS < 1) begin : g_chk_rep
    $error("REPEAT_TICKS must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
  } state_t;

  logic                  s1_q;
  logic                  s2_q;
  logic [DIV_W-1:0]      div_cnt_q;
  logic                  tick;
  logic [DEB_CYCLES-1:0] shreg_q;
  logic                  level_q;
  logic                  level_d;

  state_t                state_q;
  state_t                state_d;
  logic [HOLD_W-1:0]     hold_q;
  logic [HOLD_W-1:0]     hold_d;
  logic                  press_q;
  logic                  press_d;
  logic                  release_q;
  logic                  release_d;
  logic                  long_q;
  logic                  long_d;
  logic                  en_q;

`ifdef AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_TICKS + 1);
  logic [REP_W-1:0]      rep_q;
  logic [REP_W-1:0]      rep_d;
`endif

  assign tick = (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));

  // Two-flop synchronizer for the asynchronous button pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= bus.btn_in;
      s2_q <= s1_q;
    end
  end

  // Sample-tick prescaler: wraps at SAMPLE_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else if (tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

  // Debounced level moves only on a full run of identical samples.
  always_comb begin
    level_d = level_q;
    if (&shreg_q) begin
      level_d = 1'b1;
    end else if (~|shreg_q) begin
      level_d = 1'b0;
    end
  end

  // Sample shift register and debounced level register.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      level_q <= 1'b0;
    end else begin
      if (tick) begin
        shreg_q <= {shreg_q[DEB_CYCLES-2:0], s2_q};
      end
      level_q <= level_d;
    end
  end

  // Press FSM next state and pulse decode; release always takes priority.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
`ifdef AUTO_REPEAT_EN
    rep_d     = rep_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (level_q) begin
          state_d = PRESSED;
          press_d = 1'b1;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        if (!level_q) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (tick) begin
          if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
            state_d = LONG;
            long_d  = 1'b1;
`ifdef AUTO_REPEAT_EN
            rep_d   = '0;
`endif
          end
          if (hold_q != HOLD_W'(HOLD_TICKS)) begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      LONG: begin
        if (!level_q) begin
          state_d   = IDLE;
          release_d = 1'b1;
`ifdef AUTO_REPEAT_EN
          rep_d     = '0;
`endif
        end
`ifdef AUTO_REPEAT_EN
        else if (tick) begin
          if (rep_q == REP_W'(REPEAT_TICKS - 1)) begin
            press_d = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, counters and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      en_q      <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      en_q      <= en_q ^ press_d;
`ifdef AUTO_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;
  assign bus.en_level      = en_q;

endmodule
